// File: rtl/lvds_deser_align.sv
// rtl/lvds_deser_align.sv - serial word deserializer with sync-word frame alignment
module lvds_deser_align #(
  parameter int              WIDTH       = 12,
  parameter logic [WIDTH-1:0] SYNC_WORD  = 12'hE4B,
  parameter int              FRAME_WORDS = 4,
  parameter int              CONFIRM     = 2,
  parameter int              MAX_MISS    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             sdata_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_start,
  output logic             aligned,
  output logic             lost_sync
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WW = $clog2(FRAME_WORDS + 1);
  localparam int MW = $clog2(CONFIRM + 1);
  localparam int XW = $clog2(MAX_MISS + 1);

  localparam logic [BW-1:0] BIT_LAST     = BW'(WIDTH - 1);
  localparam logic [WW-1:0] SLOT_SYNC    = WW'(FRAME_WORDS);
  localparam logic [MW-1:0] MATCH_LAST   = MW'(CONFIRM - 1);
  localparam logic [XW-1:0] MISS_LAST    = XW'(MAX_MISS - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HUNT      = 2'd1,
    VERIFY    = 2'd2,
    LOCKED    = 2'd3
  } state_t;

  state_t           state;
  logic             lk_meta;
  logic             lk;
  // The newest bit arrives on sdata_in, so only the previous WIDTH-1 bits need storing
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] cand;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_nxt;
  logic [WW-1:0]    word_cnt;
  logic [WW-1:0]    word_nxt;
  logic [MW-1:0]    match_cnt;
  logic [XW-1:0]    miss_cnt;
  logic             is_sync;
  logic             word_done;
  logic             sync_slot;

  assign cand      = {sr, sdata_in};
  assign is_sync   = (cand == SYNC_WORD);
  assign word_done = (bit_cnt == BIT_LAST);
  assign sync_slot = (word_cnt == SLOT_SYNC);

  // Two-flop synchronizer bringing the PLL lock flag into the bit-clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk      <= lk_meta;
    end
  end

  // Free-running bit history, shifted in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= cand[WIDTH-2:0];
    end
  end

  // Bit and slot position advance once the frame phase is known
  always_comb begin
    bit_nxt  = word_done ? '0 : bit_cnt + 1'b1;
    word_nxt = word_cnt;
    if (word_done) begin
      word_nxt = sync_slot ? '0 : word_cnt + 1'b1;
    end
  end

  // Alignment state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_LOCK;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      aligned     <= 1'b0;
      lost_sync   <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      lost_sync   <= 1'b0;
      if (!lk) begin
        state     <= WAIT_LOCK;
        bit_cnt   <= '0;
        word_cnt  <= '0;
        match_cnt <= '0;
        miss_cnt  <= '0;
        aligned   <= 1'b0;
      end else begin
        case (state)
          WAIT_LOCK: begin
            state <= HUNT;
          end
          HUNT: begin
            if (is_sync) begin
              bit_cnt   <= '0;
              word_cnt  <= '0;
              match_cnt <= MW'(1);
              miss_cnt  <= '0;
              if (CONFIRM == 1) begin
                state   <= LOCKED;
                aligned <= 1'b1;
              end else begin
                state <= VERIFY;
              end
            end
          end
          VERIFY: begin
            bit_cnt  <= bit_nxt;
            word_cnt <= word_nxt;
            // Data slots are skipped; only the sync slot is judged
            if (word_done && sync_slot) begin
              if (is_sync) begin
                match_cnt <= match_cnt + 1'b1;
                if (match_cnt == MATCH_LAST) begin
                  state    <= LOCKED;
                  aligned  <= 1'b1;
                  miss_cnt <= '0;
                end
              end else begin
                state     <= HUNT;
                match_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            bit_cnt  <= bit_nxt;
            word_cnt <= word_nxt;
            if (word_done) begin
              if (!sync_slot) begin
                // Data keeps flowing even when recent syncs were missed
                data_out    <= cand;
                data_valid  <= 1'b1;
                frame_start <= (word_cnt == '0);
              end else if (is_sync) begin
                miss_cnt <= '0;
              end else if (miss_cnt == MISS_LAST) begin
                state     <= HUNT;
                aligned   <= 1'b0;
                lost_sync <= 1'b1;
                miss_cnt  <= '0;
                match_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end
          end
          default: begin
            state <= WAIT_LOCK;
          end
        endcase
      end
    end
  end

endmodule
